id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, sitting between the decode stage and the execute stage.
- Captures decoded control and operand fields each cycle and presents them as the *_ex signals the execute stage consumes.
- Inserts a one-cycle bubble and raises a stall request to IF/ID and PC on a load-use dependency.
- Supports flush (branch/jump squash) and whole-pipeline hold.

Parameters:
- DW, 32, operand/immediate data width
- AW, 5, register address width
- CW, 5, ALUCode width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- Hold  in  1  downstream freeze; register keeps current contents
- Flush  in  1  squash the instruction entering EX
- RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, RegDst_id, ALUSrcA_id, ALUSrcB_id  in  1 each  decoded controls
- ALUCode_id  in  CW  ALU operation
- Imm_id, Sa_id, RsData_id, RtData_id  in  DW each  operands
- RsAddr_id, RtAddr_id, RdAddr_id  in  AW each  register addresses
- UsesRt_id  in  1  instruction reads Rt as a source (R-type, store, beq/bne)
- RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegDst_ex, ALUSrcA_ex, ALUSrcB_ex  out  1 each  registered controls
- ALUCode_ex  out  CW
- Imm_ex, Sa_ex, RsData_ex, RtData_ex  out  DW
- RsAddr_ex, RtAddr_ex, RdAddr_ex  out  AW
- Valid_ex  out  1  EX slot holds a real instruction
- Stall  out  1  combinational; holds PC and IF/ID

Behaviour:
- Reset (sync, highest priority): all *_ex outputs and Valid_ex go to 0 on the next edge. Stall is 0 while reset is high.
- Load-use term: LoadUse = MemRead_ex & Valid_ex & (RtAddr_ex != 0) & ((RtAddr_ex == RsAddr_id) | (UsesRt_id & (RtAddr_ex == RtAddr_id))).
- Stall = LoadUse & ~Flush & ~reset. Hold does not mask Stall; the upstream stages see both.
- Per-edge priority, first match wins:
  1. reset
  2. Flush: load a bubble
  3. Hold: keep all registers unchanged
  4. LoadUse: load a bubble
  5. normal: capture all *_id inputs, Valid_ex = 1
- Bubble: every control output, Valid_ex, and every data/address field is 0, which makes the bubble a deterministic NOP.
- Latency: 1 cycle from ID to EX. No combinational path from *_id to *_ex.
- Stall lasts exactly one cycle per load-use. The next cycle MemRead_ex = 0 (bubble), so LoadUse drops and the held instruction is captured.
- Back-to-back loads with dependency: each stalls once; no deadlock.
- Flush and LoadUse together: Flush wins, Stall = 0, bubble inserted.
- Flush and Hold together: Flush wins.
- Hold with LoadUse: registers freeze and Stall stays asserted until Hold drops. The bubble is then inserted on the first non-hold edge.
- Reset mid-stall clears the state; Stall deasserts the cycle after reset because Valid_ex = 0.
- Address 0 never triggers a hazard.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- When defined, adds output BubbleCount (32 bits).
  - Increments on every edge where a load-use bubble is loaded (priority item 4).
  - Flush bubbles are not counted.
  - Cleared by reset; wraps from 0xFFFFFFFF to 0.
- When undefined, the port and the counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset for 2 cycles with non-zero *_id inputs -> all *_ex = 0, Valid_ex = 0, Stall = 0.
- Pass-through: ALUCode_id = 5'd3, RsData_id = 0x12345678, RdAddr_id = 7, RegWrite_id = 1 -> the same values appear on *_ex one edge later, Valid_ex = 1.
- Load-use:
  - EX holds lw with RtAddr_ex = 8; ID has RsAddr_id = 8 -> Stall = 1 for exactly one cycle, the next EX contents are all 0.
  - The edge after that captures the ID instruction.
  - With the feature enabled, BubbleCount = 1.
- No hazard:
  - lw with RtAddr_ex = 0, RsAddr_id = 0 -> Stall = 0.
  - lw with RtAddr_ex = 9, RtAddr_id = 9, UsesRt_id = 0 -> Stall = 0.
- Flush plus load-use in the same cycle -> Stall = 0, bubble loaded, BubbleCount unchanged.
- Hold: with Hold = 1 for 3 cycles during a load-use -> *_ex unchanged and Stall = 1 throughout; the bubble appears on the first edge after Hold falls.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection.
//                Captures the decoded instruction every cycle and presents it
//                to the execute stage. When the instruction in EX is a load
//                whose destination is a source of the instruction in ID, a
//                one-cycle bubble is loaded and Stall freezes PC and IF/ID.
//                Flush squashes the instruction entering EX; Hold freezes
//                this register.
//  Ports       : clk, reset (sync, active-high)
//                Hold, Flush              - pipeline control
//                *_id                     - decoded controls/operands/addresses
//                UsesRt_id                - instruction reads Rt as a source
//                *_ex                     - registered copies for the EX stage
//                Valid_ex                 - EX slot holds a real instruction
//                Stall                    - combinational stall request
//                BubbleCount (optional)   - count of load-use bubbles
//  Options     : ID_EX_HAZARD_STATS_EN adds the BubbleCount output/counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          Hold,
   input  logic          Flush,
   input  logic          RegWrite_id,
   input  logic          MemRead_id,
   input  logic          MemWrite_id,
   input  logic          MemtoReg_id,
   input  logic          RegDst_id,
   input  logic          ALUSrcA_id,
   input  logic          ALUSrcB_id,
   input  logic [CW-1:0] ALUCode_id,
   input  logic [DW-1:0] Imm_id,
   input  logic [DW-1:0] Sa_id,
   input  logic [DW-1:0] RsData_id,
   input  logic [DW-1:0] RtData_id,
   input  logic [AW-1:0] RsAddr_id,
   input  logic [AW-1:0] RtAddr_id,
   input  logic [AW-1:0] RdAddr_id,
   input  logic          UsesRt_id,
   output logic          RegWrite_ex,
   output logic          MemRead_ex,
   output logic          MemWrite_ex,
   output logic          MemtoReg_ex,
   output logic          RegDst_ex,
   output logic          ALUSrcA_ex,
   output logic          ALUSrcB_ex,
   output logic [CW-1:0] ALUCode_ex,
   output logic [DW-1:0] Imm_ex,
   output logic [DW-1:0] Sa_ex,
   output logic [DW-1:0] RsData_ex,
   output logic [DW-1:0] RtData_ex,
   output logic [AW-1:0] RsAddr_ex,
   output logic [AW-1:0] RtAddr_ex,
   output logic [AW-1:0] RdAddr_ex,
   output logic          Valid_ex,
`ifdef ID_EX_HAZARD_STATS_EN
   output logic [31:0]   BubbleCount,
`endif
   output logic          Stall
);

   // All captured fields travel as one packed word; a bubble is simply zero.
   localparam int c_PKT_W = 7 + CW + 4*DW + 3*AW;

   logic [c_PKT_W-1:0] w_pkt_id;
   logic [c_PKT_W-1:0] w_pkt_d;
   logic [c_PKT_W-1:0] r_pkt_q;
   logic               w_valid_d;
   logic               r_valid_q;
   logic               w_load_use;
   logic               w_lu_bubble;

   assign w_pkt_id = {RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id,
                      RegDst_id, ALUSrcA_id, ALUSrcB_id, ALUCode_id,
                      Imm_id, Sa_id, RsData_id, RtData_id,
                      RsAddr_id, RtAddr_id, RdAddr_id};

   assign {RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex,
           RegDst_ex, ALUSrcA_ex, ALUSrcB_ex, ALUCode_ex,
           Imm_ex, Sa_ex, RsData_ex, RtData_ex,
           RsAddr_ex, RtAddr_ex, RdAddr_ex} = r_pkt_q;

   assign Valid_ex = r_valid_q;

   // A load in EX whose destination feeds the ID instruction. Register 0 is
   // hard-wired, so it never creates a dependency. Rt only matters when the
   // ID instruction actually reads it (not when Rt is its destination).
   assign w_load_use = MemRead_ex & Valid_ex & (RtAddr_ex != '0) &
                       ((RtAddr_ex == RsAddr_id) |
                        (UsesRt_id & (RtAddr_ex == RtAddr_id)));

   // Hold deliberately does not mask Stall: upstream must stay frozen until
   // the bubble has actually been inserted.
   assign Stall = w_load_use & ~Flush & ~reset;

   // Load-use bubble is taken only when neither Flush nor Hold has priority.
   assign w_lu_bubble = w_load_use & ~Flush & ~Hold;

   always_comb begin
      w_pkt_d   = r_pkt_q;
      w_valid_d = r_valid_q;
      if (Flush) begin
         w_pkt_d   = '0;
         w_valid_d = 1'b0;
      end else if (Hold) begin
         w_pkt_d   = r_pkt_q;
         w_valid_d = r_valid_q;
      end else if (w_load_use) begin
         w_pkt_d   = '0;
         w_valid_d = 1'b0;
      end else begin
         w_pkt_d   = w_pkt_id;
         w_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pkt_q   <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_pkt_q   <= w_pkt_d;
         r_valid_q <= w_valid_d;
      end
   end

`ifdef ID_EX_HAZARD_STATS_EN
   logic [31:0] r_bubble_cnt_q;
   logic [31:0] w_bubble_cnt_d;

   // Natural 32-bit wrap from all-ones back to zero.
   assign w_bubble_cnt_d = w_lu_bubble ? (r_bubble_cnt_q + 32'd1) : r_bubble_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt_q <= '0;
      end else begin
         r_bubble_cnt_q <= w_bubble_cnt_d;
      end
   end

   assign BubbleCount = r_bubble_cnt_q;
`else
   // Without statistics the bubble decision has no observer beyond the
   // next-state logic; keep it referenced so the intent stays visible.
   logic w_unused_lu_bubble;
   assign w_unused_lu_bubble = w_lu_bubble;
`endif

endmodule
`default_nettype wire
